word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the 1-bit register buffer and drives its serial input.
- Accepts WIDTH-bit words over a valid/ready handshake and double-buffers them in a hold register plus a shift register.
- Emits one bit per clock with a first-bit frame marker, optionally inserting idle gap cycles between words.

Parameters:
- WIDTH, 8, word width in bits; legal values are 2 to 32.
- MSB_FIRST, 1, 1 sends in_data[WIDTH-1] first; 0 sends in_data[0] first.
- GAP_CYCLES, 0, idle cycles (out=0) inserted after each word's last bit; legal values are 0 to 15.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous reset, active-low.
- in_data  input  WIDTH  parallel word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  hold register empty; a word is accepted on an edge where in_valid and in_ready are both 1.
- out  output  1  serial bit, registered; feeds the register buffer's in.
- out_frame  output  1  registered; 1 only during the cycle in which out carries a word's first bit.
- out_active  output  1  registered; 1 while out carries a word bit.
- busy  output  1  1 when the hold register is full or state is not IDLE.

Behaviour:
- Reset: applied on a clk edge with rst_n=0.
  - After reset: out=0, out_frame=0, out_active=0, in_ready=1, busy=0.
  - Hold register is empty, state is IDLE, and both counters are 0.
  - A reset mid-word discards the shifter and hold contents; nothing is resumed after reset.
- in_ready = !hold_full. It depends only on flops and has no combinational path from in_valid.
- Accept at edge k: in_data is copied to the hold register and hold_full is set.
- State machine: IDLE, SHIFT, GAP.
  - IDLE: if hold_full, the next edge loads the shifter from hold and clears hold_full. The same edge sets out to the first bit, out_frame=1, out_active=1, bit_cnt=0, and moves to SHIFT. Otherwise outputs stay 0.
  - SHIFT: each edge presents the next bit and increments bit_cnt; out_frame=0 after the first bit.
  - SHIFT, on the edge ending bit WIDTH-1:
    - If GAP_CYCLES>0: go to GAP with out=0, out_active=0, gap_cnt=0.
    - Else if hold_full: back-to-back reload, handled exactly as IDLE→SHIFT (out_frame=1).
    - Else: go to IDLE with out=0, out_active=0.
  - GAP: out=0 for exactly GAP_CYCLES cycles. Then reload as from IDLE if hold_full, else go to IDLE.
- Latency: word accepted at edge k from IDLE with hold empty → first bit on out after edge k+1. The last bit is on out after edge k+WIDTH.
- Throughput with GAP_CYCLES=0 and in_valid held high: continuous stream with no idle bit.
- Simultaneous events: a hold→shifter load and a new accept cannot coincide, because in_ready=0 while hold is full. in_ready returns to 1 the cycle after the load.
- The shifter never changes except by a load or a shift; in_data changes while not accepted have no effect.
- bit_cnt width is clog2(WIDTH); gap_cnt width is 4. Counters never wrap past their terminal value.

Decomposition:
- Shared package serializer_pkg holds:
  - state enum ser_state_t with values IDLE, SHIFT, GAP;
  - constant CNT_W_MAX=5;
  - function clog2.
- One natural sub-module: word_hold_reg, a WIDTH-bit hold register with full flag, load/accept handshake and synchronous active-low clear.
- Shifter and FSM live in word_serializer.

Test Plan:
- Reset, WIDTH=8, MSB_FIRST=1, single word 0xA5.
  - Required: out sequence 1,0,1,0,0,1,0,1 on cycles k+1..k+8.
  - Required: out_frame=1 only at k+1; out_active=1 for those 8 cycles; then out=0 and busy=0.
- Back-to-back: words 0xFF then 0x00 with in_valid held.
  - Required: 16 consecutive active bits, 8 ones then 8 zeros, with out_frame at bit 0 and bit 8.
  - Required: the second word is accepted the cycle after the first word's load.
- Backpressure: 3 words presented continuously.
  - Required: in_ready=0 while hold is full; each word is accepted exactly once, none lost or duplicated.
- GAP_CYCLES=2: words 0x81 and 0x81 back-to-back.
  - Required: 1,0,0,0,0,0,0,1, then two cycles with out=0 and out_active=0, then the second word with out_frame=1.
- Reset mid-word: rst_n=0 for one edge after 3 bits of 0xF0.
  - Required: next cycle out=0, out_active=0, in_ready=1, busy=0; no remaining bits of 0xF0 appear.
- MSB_FIRST=0, word 0x01.
  - Required: out sequence 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the word serializer.
//   ser_state_t : serializer FSM states (IDLE, SHIFT, GAP)
//   CNT_W_MAX   : widest bit counter needed (WIDTH up to 32)
//   clog2       : ceiling log2, used to size the bit counter
package serializer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } ser_state_t;

   localparam int unsigned CNT_W_MAX = 5;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Parallel word handshake into the serializer.
//   in_data  : WIDTH-bit word
//   in_valid : in_data valid
//   in_ready : serializer can take a word (hold register empty)
// master drives data/valid, slave (the serializer) drives ready.
interface word_serializer_if
   import serializer_pkg::*;
#(
   parameter int unsigned WIDTH = 8
);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );

endinterface

// File: rtl/word_hold_reg.sv
// Single-entry hold register with full flag.
//   clk, rst_n : clock, synchronous active-low clear
//   wr_valid   : offered word; captured when the register is empty
//   wr_data    : word to capture
//   rd_take    : consumer takes the held word this edge (only while full)
//   rd_data    : held word
//   full       : register holds a word
module word_hold_reg
   import serializer_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_take,
   output logic [WIDTH-1:0] rd_data,
   output logic             full
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             full_q, full_d;

   // A take and a write cannot coincide: writes need the register empty,
   // takes need it full.
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (rd_take) begin
         full_d = 1'b0;
      end else if (wr_valid && !full_q) begin
         data_d = wr_data;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign rd_data = data_q;
   assign full    = full_q;

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial stage: double-buffers words (hold + shifter) and
// emits one bit per clock, optionally followed by idle gap cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   in_if      : word handshake (slave side)
//   out        : serial bit (registered)
//   out_frame  : out carries a word's first bit (registered)
//   out_active : out carries a word bit (registered)
//   busy       : hold register full or FSM not idle
module word_serializer
   import serializer_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   word_serializer_if.slave    in_if,
   output logic                out,
   output logic                out_frame,
   output logic                out_active,
   output logic                busy
);

   localparam int unsigned      CNT_W    = (clog2(WIDTH) > CNT_W_MAX) ? CNT_W_MAX : clog2(WIDTH);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [3:0]       GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [3:0]       gap_cnt_q, gap_cnt_d;
   logic             out_q, out_d;
   logic             frame_q, frame_d;
   logic             active_q, active_d;

   logic             take;
   logic             hold_full;
   logic [WIDTH-1:0] hold_data;

   word_hold_reg #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (in_if.in_valid),
      .wr_data  (in_if.in_data),
      .rd_take  (take),
      .rd_data  (hold_data),
      .full     (hold_full)
   );

   assign in_if.in_ready = ~hold_full;

   // The shifter keeps the word aligned so the bit after the one on out
   // always sits at the same index: [WIDTH-2] for MSB first, [1] for LSB
   // first. A load is shared by IDLE, back-to-back SHIFT and GAP exit.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      out_d     = 1'b0;
      frame_d   = 1'b0;
      active_d  = 1'b0;
      take      = 1'b0;

      unique case (state_q)
         IDLE: begin
            take = hold_full;
         end
         SHIFT: begin
            if (bit_cnt_q == BIT_LAST) begin
               if (GAP_CYCLES > 0) begin
                  state_d   = GAP;
                  gap_cnt_d = '0;
               end else if (hold_full) begin
                  take = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               active_d  = 1'b1;
               if (MSB_FIRST) begin
                  out_d   = shift_q[WIDTH-2];
                  shift_d = shift_q << 1;
               end else begin
                  out_d   = shift_q[1];
                  shift_d = shift_q >> 1;
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               if (hold_full) take = 1'b1;
               else           state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (take) begin
         state_d   = SHIFT;
         shift_d   = hold_data;
         bit_cnt_d = '0;
         out_d     = MSB_FIRST ? hold_data[WIDTH-1] : hold_data[0];
         frame_d   = 1'b1;
         active_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         out_q     <= 1'b0;
         frame_q   <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         out_q     <= out_d;
         frame_q   <= frame_d;
         active_q  <= active_d;
      end
   end

   assign out        = out_q;
   assign out_frame  = frame_q;
   assign out_active = active_q;
   assign busy       = hold_full | (state_q != IDLE);

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: three instances (MSB/no gap, MSB/gap 2,
// LSB/no gap) share clock and reset. A timeline model predicts, per
// accepted word, its load edge and hence every output cycle.
module tb_word_serializer;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       o[3], fr[3], ac[3], bz[3], rdy[3];
   logic       vld[3];
   logic [7:0] dat[3];

   word_serializer_if #(.WIDTH(W)) bus0 ();
   word_serializer_if #(.WIDTH(W)) bus1 ();
   word_serializer_if #(.WIDTH(W)) bus2 ();

   assign bus0.in_valid = vld[0];
   assign bus0.in_data  = dat[0];
   assign rdy[0]        = bus0.in_ready;
   assign bus1.in_valid = vld[1];
   assign bus1.in_data  = dat[1];
   assign rdy[1]        = bus1.in_ready;
   assign bus2.in_valid = vld[2];
   assign bus2.in_data  = dat[2];
   assign rdy[2]        = bus2.in_ready;

   word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_if(bus0.slave),
      .out(o[0]), .out_frame(fr[0]), .out_active(ac[0]), .busy(bz[0]));
   word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_if(bus1.slave),
      .out(o[1]), .out_frame(fr[1]), .out_active(ac[1]), .busy(bz[1]));
   word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_if(bus2.slave),
      .out(o[2]), .out_frame(fr[2]), .out_active(ac[2]), .busy(bz[2]));

   int gap_of[3] = '{0, 2, 0};
   bit msb_of[3] = '{1'b1, 1'b1, 1'b0};

   // model: per instance, accept edge, load edge and value of each word
   int         e;
   int         nw[3];
   int         at_e[3][64];
   int         ld_e[3][64];
   logic [7:0] wv[3][64];
   // pending words not yet accepted
   logic [7:0] pq[3][64];
   int         ph[3], pt[3];
   logic [7:0] cap[3];
   bit         rnd_gate;
   int         n_total, n_pass;

   // hold register is full after edge t
   function automatic bit m_full(int d, int t);
      for (int n = 0; n < nw[d]; n++)
         if (at_e[d][n] <= t && t < ld_e[d][n]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_busy(int d, int t);
      if (m_full(d, t)) return 1'b1;
      for (int n = 0; n < nw[d]; n++)
         if (ld_e[d][n] <= t && t < ld_e[d][n] + W + gap_of[d]) return 1'b1;
      return 1'b0;
   endfunction

   // {out, out_frame, out_active} after edge t
   function automatic logic [2:0] m_out(int d, int t);
      logic [7:0] w;
      int i;
      for (int n = 0; n < nw[d]; n++) begin
         if (ld_e[d][n] <= t && t < ld_e[d][n] + W) begin
            i = t - ld_e[d][n];
            w = wv[d][n];
            return {(msb_of[d] ? w[W-1-i] : w[i]), (i == 0), 1'b1};
         end
      end
      return 3'b000;
   endfunction

   task automatic chk(input string tag, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      assert (act === exp) n_pass++;
      else $error("FAIL %s dut%0d edge %0d: got %0h expected %0h", tag, d, e, act, exp);
   endtask

   task automatic push(input logic [7:0] w);
      for (int d = 0; d < 3; d++) begin
         pq[d][pt[d]] = w;
         pt[d]++;
      end
   endtask

   task automatic step(input bit do_rst);
      bit acc[3];
      bit v;
      int ld;
      logic [2:0] x;
      for (int d = 0; d < 3; d++) begin
         v = (ph[d] != pt[d]) && (!rnd_gate || $urandom_range(0, 3) != 0);
         vld[d] = v;
         dat[d] = v ? pq[d][ph[d]] : 8'($urandom);
         acc[d] = !do_rst && v && !m_full(d, e);
      end
      rst_n = !do_rst;
      @(posedge clk);
      e++;
      for (int d = 0; d < 3; d++) begin
         if (do_rst) begin
            nw[d] = 0;
         end else if (acc[d] && nw[d] < 64) begin
            ld = e + 1;
            if (nw[d] > 0 && ld_e[d][nw[d]-1] + W + gap_of[d] > ld)
               ld = ld_e[d][nw[d]-1] + W + gap_of[d];
            at_e[d][nw[d]] = e;
            ld_e[d][nw[d]] = ld;
            wv[d][nw[d]]   = pq[d][ph[d]];
            nw[d]++;
            ph[d]++;
         end
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         x = m_out(d, e);
         chk("out", d, 32'(o[d]), 32'(x[2]));
         chk("out_frame", d, 32'(fr[d]), 32'(x[1]));
         chk("out_active", d, 32'(ac[d]), 32'(x[0]));
         chk("in_ready", d, 32'(rdy[d]), 32'(!m_full(d, e)));
         chk("busy", d, 32'(bz[d]), 32'(m_busy(d, e)));
         if (ac[d] === 1'b1) cap[d] = {cap[d][6:0], o[d]};
      end
   endtask

   task automatic drain(input int maxc);
      int g;
      bit more;
      g = 0;
      more = 1'b1;
      while (more && g < maxc) begin
         more = 1'b0;
         for (int d = 0; d < 3; d++)
            if (ph[d] != pt[d] || m_busy(d, e)) more = 1'b1;
         if (more) begin
            step(1'b0);
            g++;
         end
      end
      n_total++;
      assert (g < maxc) n_pass++;
      else $error("FAIL drain_timeout: got %0d cycles, limit %0d", g, maxc);
      step(1'b0);
      step(1'b0);
   endtask

   initial begin
      e = 0; n_total = 0; n_pass = 0; rnd_gate = 1'b0;
      for (int d = 0; d < 3; d++) begin
         nw[d] = 0; ph[d] = 0; pt[d] = 0; cap[d] = '0;
         vld[d] = 1'b0; dat[d] = '0;
      end

      // reset state
      step(1'b1);
      step(1'b1);
      step(1'b0);

      // single word 0xA5 (bit-palindrome, same capture for LSB first)
      for (int d = 0; d < 3; d++) cap[d] = '0;
      push(8'hA5);
      drain(100);
      for (int d = 0; d < 3; d++) chk("a5_bits", d, 32'(cap[d]), 32'h0000_00A5);

      // back-to-back 0xFF then 0x00
      push(8'hFF);
      push(8'h00);
      drain(100);

      // backpressure: three words offered continuously
      push(8'($urandom));
      push(8'($urandom));
      push(8'($urandom));
      drain(150);

      // 0x81 twice (gap visible on dut1)
      push(8'h81);
      push(8'h81);
      drain(100);

      // reset after three bits of 0xF0
      push(8'hF0);
      repeat (4) step(1'b0);
      step(1'b1);
      drain(50);

      // single 0x01: MSB first ends with the one, LSB first starts with it
      for (int d = 0; d < 3; d++) cap[d] = '0;
      push(8'h01);
      drain(100);
      chk("w01_msb", 0, 32'(cap[0]), 32'h0000_0001);
      chk("w01_lsb", 2, 32'(cap[2]), 32'h0000_0080);

      // randomized words with random valid gating
      rnd_gate = 1'b1;
      for (int k = 0; k < 20; k++) push(8'($urandom));
      drain(2000);
      rnd_gate = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
